// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    localparam logic [NUM_ROWS-1:0] ROW_RESET = 4'b0001;

    function automatic logic [NUM_ROWS-1:0] row_onehot(input logic [1:0] idx);
        return ROW_RESET << idx;
    endfunction

endpackage

// File: rtl/keypad_onehot_decode.sv
// Classifies a column pattern as a single pressed key and returns its column index.
module keypad_onehot_decode
    import keypad_pkg::*;
(
    input  logic [NUM_COLS-1:0] column,
    output logic                is_onehot,
    output logic [1:0]          index
);

    // Only an exact single-bit pattern counts as a key; zero or several bits do not.
    always_comb begin
        is_onehot = 1'b0;
        index     = 2'd0;
        case (column)
            4'b0001: begin is_onehot = 1'b1; index = 2'd0; end
            4'b0010: begin is_onehot = 1'b1; index = 2'd1; end
            4'b0100: begin is_onehot = 1'b1; index = 2'd2; end
            4'b1000: begin is_onehot = 1'b1; index = 2'd3; end
            default: begin is_onehot = 1'b0; index = 2'd0; end
        endcase
    end

endmodule

// File: rtl/keypad_scan_controller.sv
// Row-scanning keypad controller: settles each row, debounces press and release,
// and emits a one-cycle key event with the accepted key index.
module keypad_scan_controller
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_COLS-1:0] stabilized_column,
    output logic [NUM_ROWS-1:0] keypad_row,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam int MAX_COUNT = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W     = $clog2(MAX_COUNT) + 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

    scan_state_t         state_r, state_s;
    logic [1:0]          row_idx_r, row_idx_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s, cnt_inc_s;
    logic [NUM_COLS-1:0] col_pat_r, col_pat_s;
    logic [1:0]          col_idx_r, col_idx_s;
    logic [3:0]          key_code_r, key_code_s;
    logic                key_valid_r, key_valid_s;
    logic                key_held_r, key_held_s;
    logic [NUM_ROWS-1:0] keypad_row_r;
    logic                col_onehot_s;
    logic [1:0]          col_dec_idx_s;
    logic                col_match_s;

    keypad_onehot_decode u_decode (
        .column    (stabilized_column),
        .is_onehot (col_onehot_s),
        .index     (col_dec_idx_s)
    );

    assign cnt_inc_s   = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
    assign col_match_s = (stabilized_column == col_pat_r);

    // Next-state, counter and output decisions for the scan/debounce FSM.
    always_comb begin
        state_s     = state_r;
        row_idx_s   = row_idx_r;
        cnt_s       = cnt_r;
        col_pat_s   = col_pat_r;
        col_idx_s   = col_idx_r;
        key_code_s  = key_code_r;
        key_valid_s = 1'b0;
        key_held_s  = key_held_r;
        case (state_r)
            SCAN: begin
                key_held_s = 1'b0;
                if (cnt_r >= SETTLE_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (col_onehot_s) begin
                        col_pat_s = stabilized_column;
                        col_idx_s = col_dec_idx_s;
                        state_s   = DEBOUNCE;
                    end else begin
                        row_idx_s = row_idx_r + 2'd1;
                    end
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            DEBOUNCE: begin
                if (!col_match_s) begin
                    state_s = SCAN;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r >= DEB_LAST) begin
                    state_s     = PRESSED;
                    cnt_s       = CNT_ZERO;
                    key_code_s  = {row_idx_r, col_idx_r};
                    key_valid_s = 1'b1;
                    key_held_s  = 1'b1;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            PRESSED: begin
                key_held_s = 1'b1;
                if (col_match_s) begin
                    state_s = PRESSED;
                end else begin
                    state_s = RELEASE;
                    cnt_s   = CNT_ZERO;
                end
            end
            RELEASE: begin
                key_held_s = 1'b1;
                // A returning pattern is release bounce: resume PRESSED without a new event.
                if (col_match_s) begin
                    state_s = PRESSED;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r >= DEB_LAST) begin
                    state_s    = SCAN;
                    cnt_s      = CNT_ZERO;
                    key_held_s = 1'b0;
                    row_idx_s  = row_idx_r + 2'd1;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            default: begin
                state_s    = SCAN;
                cnt_s      = CNT_ZERO;
                key_held_s = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= SCAN;
            row_idx_r    <= 2'd0;
            cnt_r        <= CNT_ZERO;
            col_pat_r    <= 4'd0;
            col_idx_r    <= 2'd0;
            key_code_r   <= 4'd0;
            key_valid_r  <= 1'b0;
            key_held_r   <= 1'b0;
            keypad_row_r <= ROW_RESET;
        end else begin
            state_r      <= state_s;
            row_idx_r    <= row_idx_s;
            cnt_r        <= cnt_s;
            col_pat_r    <= col_pat_s;
            col_idx_r    <= col_idx_s;
            key_code_r   <= key_code_s;
            key_valid_r  <= key_valid_s;
            key_held_r   <= key_held_s;
            keypad_row_r <= row_onehot(row_idx_s);
        end
    end

    assign keypad_row = keypad_row_r;
    assign key_code   = key_code_r;
    assign key_valid  = key_valid_r;
    assign key_held   = key_held_r;

endmodule

// File: doc/keypad_scan_controller.md
Name: keypad_scan_controller

Overview:
Sequences the 4x4 keypad scan. Drives one row at a time and samples the synchronized column bus from keypad_column_synchronizer, which adds 2 cycles of latency. Debounces presses and releases, then emits a one-cycle key event with a 4-bit key index for downstream display and decode logic.

Parameters:
SETTLE_CYCLES, 4, cycles each row is driven before its columns are sampled; must be >= 3 to cover synchronizer latency.
DEBOUNCE_CYCLES, 20000, consecutive stable cycles required to accept a press or a release; must be >= 2.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
stabilized_column  input  4  synchronized column bus; active-high; bit c set = key in column c on the driven row is pressed
keypad_row  output  4  one-hot, active-high row drive
key_code  output  4  accepted key index = row_idx*4 + col_idx; held until the next accepted press
key_valid  output  1  one-cycle pulse when a press is accepted
key_held  output  1  high while the accepted key is considered down, including during release debounce

Behaviour:
- Reset (async assert, sync deassert by the environment):
  - state=SCAN, row_idx=0, keypad_row=4'b0001.
  - Counters=0, key_code=0, key_valid=0, key_held=0.
- All outputs are registered. keypad_row always equals 1<<row_idx.
- Column pattern is "valid" only when exactly one bit of stabilized_column is set. Zero bits or multiple bits count as no valid key.
- SCAN:
  - cnt increments each cycle.
  - At cnt==SETTLE_CYCLES-1, sample the column bus:
    - Valid: latch col_pat and col_idx, cnt=0, go to DEBOUNCE.
    - Not valid: row_idx=(row_idx+1) mod 4, cnt=0.
  - Any row change restarts the settle count.
- DEBOUNCE:
  - Row is frozen.
  - If stabilized_column != col_pat on any cycle: go to SCAN, same row, cnt=0.
  - If it matches for DEBOUNCE_CYCLES consecutive cycles: go to PRESSED.
  - On that same transition: key_code={row_idx[1:0],col_idx[1:0]}, key_valid=1 for exactly the next cycle, key_held=1.
- PRESSED:
  - Row is frozen; key_held=1.
  - If stabilized_column==col_pat: stay.
  - Any other value, including a second key, zero, or multi-bit: go to RELEASE, cnt=0.
  - No rollover: a second simultaneous key never generates an event.
- RELEASE:
  - key_held stays 1.
  - If stabilized_column==col_pat: return to PRESSED with no new key_valid. This covers bounce on release.
  - Any other value for DEBOUNCE_CYCLES consecutive cycles: key_held=0, row_idx=(row_idx+1) mod 4, cnt=0, go to SCAN.
- Row wrap: row 3 -> row 0.
- Exactly one key_valid pulse per physical press, even with bounce on either edge.
- Latency:
  - Press on row r while row r is driven: key_valid rises SETTLE_CYCLES + DEBOUNCE_CYCLES + 1 cycles after the first valid sample (±1 for sample alignment).
  - Worst-case detection start is 4*SETTLE_CYCLES after the press.
- Reset asserted mid-operation: immediate return to reset values. A pending event is dropped; no key_valid is generated.
- Counter widths: $clog2 of the largest count + 1. Counters saturate rather than wrap.

Decomposition:
- Package keypad_pkg:
  - typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} scan_state_t.
  - NUM_ROWS=4, NUM_COLS=4.
  - Row one-hot constant for reset (4'b0001).
- Sub-module keypad_onehot_decode (combinational):
  - Input: 4-bit column.
  - Outputs: is_onehot and the 2-bit index.
  - Used for the SCAN sample check and the col_idx latch.
- The FSM and counters stay in the top module.

Test Plan:
Use SETTLE_CYCLES=3 and DEBOUNCE_CYCLES=5 for all scenarios.
1. Reset and idle: hold reset low for 2 cycles, columns=0 -> keypad_row=0001, outputs 0; after release, keypad_row cycles 0001->0010->0100->1000->0001 every 3 cycles; key_valid never asserts.
2. Clean press row 2 / col 1: bench model returns 4'b0010 (through a 2-cycle synchronizer model) only while keypad_row=0100 -> exactly one key_valid pulse with key_code=4'd9; key_held=1 until 5 cycles after the column is released; scanning then resumes at row 3.
3. Press bounce: column toggles 0010/0000 every 2 cycles for 12 cycles, then stable -> no key_valid during the bounce; one pulse after 5 stable cycles; key_code=9.
4. Release bounce: after acceptance, column drops to 0 for 3 cycles and returns to 0010, then drops permanently -> key_held stays 1 throughout the bounce; no second key_valid; key_held falls 5 cycles after the final drop.
5. Multi-key: column=4'b0110 on row 0 -> treated as no key, scan continues; key 0/col 3 pressed, then a second key added while PRESSED -> single key_valid with key_code=3; no event for the second key.
6. Reset mid-debounce: assert reset at DEBOUNCE cnt=3 -> immediate keypad_row=0001, key_valid=0, key_held=0, state=SCAN; no event afterward while the columns are held at 0.
